// File: rtl/fetch_pcgen_pkg.sv
// Shared sizes, packet layout and FSM encodings for the fetch PC generator.
package fetch_pcgen_pkg;

  localparam int SIZE_ADDR = 32;
  localparam int SIZE_FPKT = 1 + 2*SIZE_ADDR;

  // Packet layout, MSB to LSB: {pc, pred_taken, pred_target}
  localparam int FPKT_TGT_LSB   = 0;
  localparam int FPKT_TGT_MSB   = SIZE_ADDR - 1;
  localparam int FPKT_TAKEN_BIT = SIZE_ADDR;
  localparam int FPKT_PC_LSB    = SIZE_ADDR + 1;
  localparam int FPKT_PC_MSB    = 2*SIZE_ADDR;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } fstate_e;

  typedef struct packed {
    logic [SIZE_ADDR-1:0] pc;
    logic                 pred_taken;
    logic [SIZE_ADDR-1:0] pred_target;
  } fpkt_t;

  function automatic fpkt_t fpkt_unpack(input logic [SIZE_FPKT-1:0] v);
    fpkt_t p;
    p.pc          = v[FPKT_PC_MSB:FPKT_PC_LSB];
    p.pred_taken  = v[FPKT_TAKEN_BIT];
    p.pred_target = v[FPKT_TGT_MSB:FPKT_TGT_LSB];
    return p;
  endfunction

endpackage

// File: rtl/fetch_pcgen_if.sv
// Predictor lookup, decode-side packet handshake and execute redirect.
interface fetch_pcgen_if;
  import fetch_pcgen_pkg::*;

  logic [SIZE_ADDR-1:0] ow_pc;
  logic                 iw_pred_taken;
  logic [SIZE_ADDR-1:0] iw_pred_target;
  logic                 ow_f_valid;
  logic [SIZE_ADDR-1:0] ow_f_pc;
  logic                 ow_f_pred_taken;
  logic [SIZE_ADDR-1:0] ow_f_pred_target;
  logic                 iw_f_ready;
  logic                 iw_redirect;
  logic [SIZE_ADDR-1:0] iw_redirect_pc;

  modport master (
    output ow_pc, ow_f_valid, ow_f_pc, ow_f_pred_taken, ow_f_pred_target,
    input  iw_pred_taken, iw_pred_target, iw_f_ready, iw_redirect, iw_redirect_pc
  );

  modport slave (
    input  ow_pc, ow_f_valid, ow_f_pc, ow_f_pred_taken, ow_f_pred_target,
    output iw_pred_taken, iw_pred_target, iw_f_ready, iw_redirect, iw_redirect_pc
  );

endinterface

// File: rtl/fetch_pcgen_fifo.sv
// Packet buffer: synchronous flush, push and pop together even when full.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  // Storage clears on reset so head reads zero; flush only rewinds pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_pcgen.sv
// Fetch-stage PC generator: FSM, next-PC mux and packet buffer for decode.
// Macro FETCH_PRED_EN: when defined, the predictor's taken/target steer fetch
// and are recorded in packets; otherwise fetch is strictly sequential and
// packets carry {taken=0, target=pc+1}.
module fetch_pcgen import fetch_pcgen_pkg::*; #(
  parameter int                   FIFO_DEPTH = 2,
  parameter logic [SIZE_ADDR-1:0] RESET_PC   = '0
) (
  input logic           iw_clk,
  input logic           iw_rst,
  fetch_pcgen_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fstate_e              state;
  logic [SIZE_ADDR-1:0] r_pc, pc_inc, next_pc, pkt_target;
  logic                 pkt_taken;
  logic                 push, pop, full, empty;
  logic [CNT_W-1:0]     count, count_nxt;
  logic [SIZE_FPKT-1:0] wdata, rdata;
  fpkt_t                head;

  assign pc_inc = r_pc + SIZE_ADDR'(1);

`ifdef FETCH_PRED_EN
  assign pkt_taken  = bus.iw_pred_taken;
  assign pkt_target = bus.iw_pred_target;
  assign next_pc    = bus.iw_pred_taken ? bus.iw_pred_target : pc_inc;
`else
  logic unused_pred;
  assign unused_pred = ^{bus.iw_pred_taken, bus.iw_pred_target};
  assign pkt_taken   = 1'b0;
  assign pkt_target  = pc_inc;
  assign next_pc     = pc_inc;
`endif

  // A redirect discards any same-cycle pop or push; IDLE never pushes.
  assign pop   = ~empty & bus.iw_f_ready & ~bus.iw_redirect;
  assign push  = (state != S_IDLE) & ~bus.iw_redirect & (~full | pop);
  assign wdata = {r_pc, pkt_taken, pkt_target};

  // Occupancy after this edge decides between RUN and HOLD.
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SIZE_FPKT)
  ) u_fifo (
    .clk   (iw_clk),
    .rst   (iw_rst),
    .flush (bus.iw_redirect),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Fetch FSM and PC register; PC only advances when its packet is enqueued.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state <= S_IDLE;
      r_pc  <= RESET_PC;
    end else if (bus.iw_redirect) begin
      state <= S_RUN;
      r_pc  <= bus.iw_redirect_pc;
    end else begin
      case (state)
        S_IDLE: state <= S_RUN;
        S_RUN, S_HOLD: begin
          if (push) r_pc <= next_pc;
          state <= (count_nxt == CNT_W'(FIFO_DEPTH)) ? S_HOLD : S_RUN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign head                 = fpkt_unpack(rdata);
  assign bus.ow_pc            = r_pc;
  assign bus.ow_f_valid       = ~empty;
  assign bus.ow_f_pc          = head.pc;
  assign bus.ow_f_pred_taken  = head.pred_taken;
  assign bus.ow_f_pred_target = head.pred_target;

endmodule

// File: tb/tb_fetch_pcgen.sv
// Directed bench for fetch_pcgen; expectations follow FETCH_PRED_EN.
module tb_fetch_pcgen;
  import fetch_pcgen_pkg::*;

  logic iw_clk = 1'b0;
  logic iw_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Predictor model: one taken entry (br_on) or everything taken (br_all).
  logic                 br_on = 1'b0, br_all = 1'b0;
  logic [SIZE_ADDR-1:0] br_pc = '0, br_tgt = '0;

  fetch_pcgen_if bus ();

  fetch_pcgen #(
    .FIFO_DEPTH (2),
    .RESET_PC   (32'h10)
  ) dut (
    .iw_clk (iw_clk),
    .iw_rst (iw_rst),
    .bus    (bus)
  );

  always #5 iw_clk = ~iw_clk;

  always_comb begin
    bus.iw_pred_taken  = br_all | (br_on && bus.ow_pc == br_pc);
    bus.iw_pred_target = bus.iw_pred_taken ? br_tgt : bus.ow_pc + 32'd1;
  end

`ifdef FETCH_PRED_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iw_clk);
      #1;
    end
  endtask

  // Holds reset for two edges; the next edge after return is the first with rst low.
  task automatic do_reset(input logic rdy);
    iw_rst = 1'b1;
    bus.iw_redirect = 1'b0;
    bus.iw_redirect_pc = '0;
    bus.iw_f_ready = rdy;
    br_on = 1'b0;
    br_all = 1'b0;
    step(2);
    iw_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    checks++; if (bus.ow_f_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", bus.ow_f_valid); end
    checks++; if (bus.ow_f_pc !== 32'h0) begin errors++; $display("FAIL reset_head_pc: got %h exp 0", bus.ow_f_pc); end
    checks++; if (bus.ow_f_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_head_taken: got %b exp 0", bus.ow_f_pred_taken); end
    checks++; if (bus.ow_f_pred_target !== 32'h0) begin errors++; $display("FAIL reset_head_target: got %h exp 0", bus.ow_f_pred_target); end
    checks++; if (bus.ow_pc !== 32'h10) begin errors++; $display("FAIL reset_pc: got %h exp 10", bus.ow_pc); end
    checks++; if (dut.state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dut.state, S_IDLE); end
  endtask

  task automatic test_startup_predict();
    logic [31:0] ep;
    do_reset(1'b1);
    br_on = 1'b1; br_pc = 32'h12; br_tgt = 32'h40;
    step(1);
    checks++; if (bus.ow_f_valid !== 1'b0) begin errors++; $display("FAIL start_edge1_valid: got %b exp 0", bus.ow_f_valid); end
    for (int k = 0; k < 3; k++) begin
      step(1);
      ep = 32'h10 + k;
      checks++; if (bus.ow_f_valid !== 1'b1 || bus.ow_f_pc !== ep) begin errors++; $display("FAIL start_pkt%0d: got v=%b pc=%h exp v=1 pc=%h", k, bus.ow_f_valid, bus.ow_f_pc, ep); end
    end
    checks++; if (bus.ow_f_pred_taken !== PRED || bus.ow_f_pred_target !== (PRED ? 32'h40 : 32'h13)) begin errors++; $display("FAIL pred_fields: got %b/%h exp %b/%h", bus.ow_f_pred_taken, bus.ow_f_pred_target, PRED, PRED ? 32'h40 : 32'h13); end
    step(1);
    ep = PRED ? 32'h40 : 32'h13;
    checks++; if (bus.ow_f_pc !== ep) begin errors++; $display("FAIL pred_next_pc: got %h exp %h", bus.ow_f_pc, ep); end
    br_on = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] ep;
    do_reset(1'b0);
    step(3);
    checks++; if (bus.ow_f_valid !== 1'b1 || bus.ow_f_pc !== 32'h10) begin errors++; $display("FAIL bp_head_early: got v=%b pc=%h exp v=1 pc=10", bus.ow_f_valid, bus.ow_f_pc); end
    step(2);
    checks++; if (dut.state !== S_HOLD) begin errors++; $display("FAIL bp_state: got %0d exp %0d", dut.state, S_HOLD); end
    checks++; if (dut.count !== 2'd2) begin errors++; $display("FAIL bp_count: got %0d exp 2", dut.count); end
    checks++; if (bus.ow_pc !== 32'h12) begin errors++; $display("FAIL bp_ow_pc: got %h exp 12", bus.ow_pc); end
    checks++; if (bus.ow_f_pc !== 32'h10 || bus.ow_f_pred_target !== 32'h11) begin errors++; $display("FAIL bp_head_stable: got pc=%h tgt=%h exp 10/11", bus.ow_f_pc, bus.ow_f_pred_target); end
    bus.iw_f_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step(1);
      ep = 32'h10 + k;
      checks++; if (bus.ow_f_valid !== 1'b1 || bus.ow_f_pc !== ep) begin errors++; $display("FAIL bp_drain%0d: got v=%b pc=%h exp v=1 pc=%h", k, bus.ow_f_valid, bus.ow_f_pc, ep); end
    end
  endtask

  task automatic test_redirect_full();
    do_reset(1'b0);
    step(5);
    bus.iw_f_ready = 1'b1;
    bus.iw_redirect = 1'b1;
    bus.iw_redirect_pc = 32'h80;
    step(1);
    bus.iw_redirect = 1'b0;
    checks++; if (bus.ow_f_valid !== 1'b0) begin errors++; $display("FAIL redir_gap_valid: got %b exp 0", bus.ow_f_valid); end
    checks++; if (bus.ow_pc !== 32'h80 || dut.state !== S_RUN) begin errors++; $display("FAIL redir_pc_state: got pc=%h st=%0d exp 80/%0d", bus.ow_pc, dut.state, S_RUN); end
    step(1);
    checks++; if (bus.ow_f_valid !== 1'b1 || bus.ow_f_pc !== 32'h80) begin errors++; $display("FAIL redir_head: got v=%b pc=%h exp v=1 pc=80", bus.ow_f_valid, bus.ow_f_pc); end
    step(1);
    checks++; if (bus.ow_f_pc !== 32'h81) begin errors++; $display("FAIL redir_next: got %h exp 81", bus.ow_f_pc); end
  endtask

  task automatic test_wrap_selfloop();
    logic [31:0] ep;
    // Redirect on the first edge after reset, while still in IDLE.
    do_reset(1'b1);
    bus.iw_redirect = 1'b1;
    bus.iw_redirect_pc = 32'hFFFF_FFFF;
    step(1);
    bus.iw_redirect = 1'b0;
    checks++; if (bus.ow_f_valid !== 1'b0) begin errors++; $display("FAIL wrap_gap_valid: got %b exp 0", bus.ow_f_valid); end
    step(1);
    checks++; if (bus.ow_f_pc !== 32'hFFFF_FFFF || bus.ow_f_pred_target !== 32'h0) begin errors++; $display("FAIL wrap_head: got pc=%h tgt=%h exp ffffffff/0", bus.ow_f_pc, bus.ow_f_pred_target); end
    step(1);
    checks++; if (bus.ow_f_pc !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h exp 0", bus.ow_f_pc); end
    br_on = 1'b1; br_pc = 32'h200; br_tgt = 32'h200;
    bus.iw_redirect = 1'b1;
    bus.iw_redirect_pc = 32'h200;
    step(1);
    bus.iw_redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      ep = PRED ? 32'h200 : 32'h200 + k;
      checks++; if (bus.ow_f_valid !== 1'b1 || bus.ow_f_pc !== ep) begin errors++; $display("FAIL selfloop%0d: got v=%b pc=%h exp v=1 pc=%h", k, bus.ow_f_valid, bus.ow_f_pc, ep); end
    end
    br_on = 1'b0;
  endtask

  task automatic test_forced_taken();
    logic [31:0] ep, et;
    do_reset(1'b1);
    br_all = 1'b1; br_tgt = 32'h40;
    bus.iw_redirect = 1'b1;
    bus.iw_redirect_pc = 32'h100;
    step(1);
    bus.iw_redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      ep = PRED ? ((k == 0) ? 32'h100 : 32'h40) : 32'h100 + k;
      et = PRED ? 32'h40 : ep + 32'd1;
      checks++; if (bus.ow_f_pc !== ep || bus.ow_f_pred_taken !== PRED || bus.ow_f_pred_target !== et) begin errors++; $display("FAIL forced%0d: got %h/%b/%h exp %h/%b/%h", k, bus.ow_f_pc, bus.ow_f_pred_taken, bus.ow_f_pred_target, ep, PRED, et); end
    end
    br_all = 1'b0;
  endtask

  initial begin
    bus.iw_f_ready = 1'b0;
    bus.iw_redirect = 1'b0;
    bus.iw_redirect_pc = '0;
    test_reset();
    test_startup_predict();
    test_backpressure();
    test_redirect_full();
    test_wrap_selfloop();
    test_forced_taken();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pcgen.md
Name: fetch_pcgen

Overview:
- Fetch-stage PC generator. Drives the lookup PC into the branch predictor and consumes its same-cycle taken/target answer to pick the next PC.
- Buffers each fetched slot as a packet {pc, pred_taken, pred_target} in a small FIFO for decode.
- Execute later compares the predicted fields against the resolved outcome.
- On a mispredict, execute asserts a redirect, which flushes the buffer and restarts fetch.

Parameters:
- FIFO_DEPTH, 2, packet buffer entries; power of two, ≥2.
- RESET_PC, 0, fetch address loaded on reset; `SIZE_ADDR bits.

Ports:
- iw_clk  input  1  clock.
- iw_rst  input  1  reset, synchronous, active-high.
- ow_pc  output  `SIZE_ADDR  current fetch PC; to predictor lookup and instruction memory.
- iw_pred_taken  input  1  predictor taken for ow_pc; combinational, same cycle.
- iw_pred_target  input  `SIZE_ADDR  predictor target for ow_pc.
- ow_f_valid  output  1  FIFO head packet valid.
- ow_f_pc  output  `SIZE_ADDR  head packet PC.
- ow_f_pred_taken  output  1  head packet predicted taken.
- ow_f_pred_target  output  `SIZE_ADDR  head packet predicted target.
- iw_f_ready  input  1  decode accepts head packet; pop when valid & ready.
- iw_redirect  input  1  execute mispredict/redirect request.
- iw_redirect_pc  input  `SIZE_ADDR  restart address.

Behaviour:
- Clock is iw_clk. Reset iw_rst is synchronous, active-high, and overrides every other input.
- Reset state: r_pc=RESET_PC, FIFO empty, state=S_IDLE, ow_f_valid=0, head outputs 0, ow_pc=RESET_PC.
- FSM S_IDLE:
  - First edge with rst low goes to S_RUN; no push.
  - Redirect in S_IDLE loads r_pc and goes to S_RUN.
- FSM S_RUN:
  - Each edge: push = !full | pop.
  - On push, enqueue {r_pc, iw_pred_taken, iw_pred_target}.
  - Next PC: r_pc <= iw_pred_taken ? iw_pred_target : r_pc+1.
  - If FIFO becomes full with no pop, go to S_HOLD.
- FSM S_HOLD:
  - r_pc and FIFO contents held.
  - On pop, push in the same edge (simultaneous pop+push allowed when full) and stay in S_HOLD.
  - The push path is unchanged from S_RUN; no lookup is lost.
  - Go to S_RUN when count < FIFO_DEPTH after the edge.
- Redirect (any non-reset state):
  - Flush FIFO (count=0, pointers reset) and set r_pc=iw_redirect_pc; state goes to S_RUN.
  - Any pop or push in the same cycle is discarded.
  - ow_f_valid=0 for exactly one cycle; the next edge pushes redirect_pc.
- Latency:
  - Reset release to first valid packet = 2 edges.
  - Redirect to valid packet = 2 edges.
  - Push to visible at head = 1 edge when FIFO was empty.
- Arithmetic: r_pc+1 wraps modulo 2^`SIZE_ADDR. A predicted target equal to r_pc (self-loop) is legal and refetches the same PC each cycle.
- Head outputs are registered/FIFO-read values and are stable while valid & !ready.
- ow_pc is the r_pc register and is glitch-free for the predictor lookup.

Optional Feature:
- FETCH_PRED_EN defined: behaviour as above.
- FETCH_PRED_EN undefined:
  - iw_pred_taken and iw_pred_target are ignored.
  - Next PC is always r_pc+1.
  - Packets carry pred_taken=0 and pred_target=r_pc+1, so execute treats every taken branch as a mispredict.

Decomposition:
- Shared package/header (sizes.vh additions):
  - `SIZE_FPKT = 1+2*`SIZE_ADDR (packet width).
  - Packet field bit-offset macros.
  - FSM state encodings S_IDLE=2'd0, S_RUN=2'd1, S_HOLD=2'd2.
- Sub-module fetch_fifo:
  - Parameters: depth, width.
  - Synchronous flush input, simultaneous push/pop when full, count, full, empty.
- fetch_pcgen holds the FSM and next-PC mux.

Test Plan:
- Reset, RESET_PC=0x10, predictor not-taken, ready=1 → ow_f_valid rises 2 edges after release; packets 0x10, 0x11, 0x12 with pred_taken=0.
- Predictor returns taken/0x40 at PC 0x12 → packet 0x12 carries {1, 0x40}; next packet PC=0x40.
- ready=0 for 5 cycles → FIFO fills to 2 (0x10, 0x11) and state is S_HOLD; ow_pc holds 0x12; after ready=1, order 0x10, 0x11, 0x12 with no gap or duplicate.
- Redirect to 0x80 with FIFO full and ready=1 in the same cycle → no pop counted; next cycle valid=0; following cycle head pc=0x80.
- PC=all-ones, not-taken → next packet PC=0 (wrap); target=own PC repeats PC every cycle.
- Build without FETCH_PRED_EN, predictor forced taken/0x40 → sequential PCs; pred_taken=0; pred_target=pc+1.
